sd_card_dat: RTL and testbench

SD_CARD_DAT -- requirements
Module: sd_card_dat

---
 rtl/sd_card_dat.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_sd_card_dat.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_dat.sv
// SD card DAT-line engine (card side): 4-bit block reads/writes, CRC16 per line, status token and busy.
// Optional macro SD_CARD_DAT_CRC_EN: generate read CRC16 and check received write CRC16.

module sd_card_dat_crc16 (
    input  logic [15:0] crc_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);
    logic fb;
    assign fb    = crc_i[15] ^ bit_i;
    assign crc_o = {crc_i[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
endmodule

module sd_card_dat #(
    parameter int NAC         = 2,
    parameter int BUSY_CYCLES = 8
) (
    input  logic        sd_clk,
    input  logic        rst,
    input  logic        rd_start,
    input  logic        wr_start,
    input  logic        abort,
    input  logic [11:0] block_sz,
    input  logic [15:0] block_cnt,
    input  logic        multiple,
    input  logic [31:0] card_tx_data,
    output logic        card_tx_rd,
    output logic [31:0] card_rx_data,
    output logic        card_rx_wr,
    input  logic [3:0]  DAT_din,
    output logic [3:0]  DAT_dout,
    output logic        DAT_dout_oe,
    output logic        busy,
    output logic        crc_err,
    output logic        xfer_done
);
    typedef enum logic [3:0] {
        IDLE, RD_WAIT, RD_START, RD_DATA, RD_CRC, RD_END,
        WR_WAIT, WR_DATA, WR_CRC, WR_END, WR_TURN, WR_STATUS, WR_BUSY, WR_REL
    } state_t;

    localparam logic [15:0] NAC_LAST  = 16'(NAC - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_CYCLES - 1);

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [12:0]      nib_q, nib_d;
    logic [15:0]      blk_q, blk_d;
    logic [11:0]      bsz_q, bsz_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      rx_data_q, rx_data_d;
    logic             rx_wr_q, rx_wr_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic [3:0][15:0] crc_q, crc_d, crc_nxt;
    logic [3:0][15:0] rxcrc_q, rxcrc_d;
    logic [3:0]       rd_nib, data_nib;
    logic [15:0]      eff_cnt;
    logic [4:0]       status_tok;
    logic             last_nib, crc_match;

    // First nibble of each word comes straight from the show-ahead head word.
    assign rd_nib   = (nib_q[2:0] == 3'd0) ? card_tx_data[31:28] : word_q[31:28];
    assign data_nib = (state_q == RD_DATA) ? rd_nib : DAT_din;
    assign last_nib = (nib_q == ({bsz_q, 1'b0} - 13'd1));
    assign eff_cnt  = multiple ? block_cnt : 16'd1;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        sd_card_dat_crc16 u_crc (.crc_i(crc_q[i]), .bit_i(data_nib[i]), .crc_o(crc_nxt[i]));
    end

`ifdef SD_CARD_DAT_CRC_EN
    assign crc_match = (crc_q == rxcrc_q);
`else
    assign crc_match = 1'b1;
`endif

    assign busy         = (state_q != IDLE);
    assign card_rx_data = rx_data_q;
    assign card_rx_wr   = rx_wr_q;
    assign xfer_done    = done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nib_d       = nib_q;
        blk_d       = blk_q;
        bsz_d       = bsz_q;
        word_d      = word_q;
        rx_data_d   = rx_data_q;
        rx_wr_d     = 1'b0;
        done_d      = 1'b0;
        ok_d        = ok_q;
        crc_d       = crc_q;
        rxcrc_d     = rxcrc_q;
        DAT_dout    = 4'hF;
        DAT_dout_oe = 1'b0;
        card_tx_rd  = 1'b0;
        crc_err     = 1'b0;
        status_tok  = (ok_q ? 5'b00101 : 5'b01011) << cnt_q[2:0];

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                nib_d = '0;
                crc_d = '0;
                if (rd_start || wr_start) begin
                    blk_d = eff_cnt;
                    bsz_d = block_sz;
                    if (eff_cnt == 16'd0 || block_sz == 12'd0) done_d = 1'b1;
                    else if (rd_start) state_d = (NAC == 0) ? RD_START : RD_WAIT;
                    else state_d = WR_WAIT;
                end
            end
            RD_WAIT: begin
                crc_d = '0;
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == NAC_LAST) begin
                    cnt_d   = '0;
                    state_d = RD_START;
                end
            end
            RD_START: begin
                DAT_dout_oe = 1'b1;
                DAT_dout    = 4'h0;
                crc_d       = '0;
                nib_d       = '0;
                state_d     = RD_DATA;
            end
            RD_DATA: begin
                DAT_dout_oe = 1'b1;
                DAT_dout    = rd_nib;
                crc_d       = crc_nxt;
                nib_d       = nib_q + 13'd1;
                if (nib_q[2:0] == 3'd0) begin
                    card_tx_rd = 1'b1;
                    word_d     = {card_tx_data[27:0], 4'h0};
                end else begin
                    word_d     = {word_q[27:0], 4'h0};
                end
                if (last_nib) begin
                    nib_d   = '0;
                    cnt_d   = '0;
                    state_d = RD_CRC;
                end
            end
            RD_CRC: begin
                DAT_dout_oe = 1'b1;
`ifdef SD_CARD_DAT_CRC_EN
                DAT_dout = {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]};
`else
                DAT_dout = 4'h0;
`endif
                for (int i = 0; i < 4; i++) crc_d[i] = {crc_q[i][14:0], 1'b0};
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd15) begin
                    cnt_d   = '0;
                    state_d = RD_END;
                end
            end
            RD_END: begin
                DAT_dout_oe = 1'b1;
                DAT_dout    = 4'hF;
                if (blk_q > 16'd1) begin
                    blk_d   = blk_q - 16'd1;
                    state_d = (NAC == 0) ? RD_START : RD_WAIT;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            WR_WAIT: begin
                crc_d = '0;
                nib_d = '0;
                if (DAT_din == 4'h0) state_d = WR_DATA;
            end
            WR_DATA: begin
                crc_d  = crc_nxt;
                nib_d  = nib_q + 13'd1;
                word_d = {word_q[27:0], DAT_din};
                if (nib_q[2:0] == 3'd7) begin
                    rx_wr_d   = 1'b1;
                    rx_data_d = {word_q[27:0], DAT_din};
                end
                if (last_nib) begin
                    cnt_d   = '0;
                    state_d = WR_CRC;
                end
            end
            WR_CRC: begin
                for (int i = 0; i < 4; i++) rxcrc_d[i] = {rxcrc_q[i][14:0], DAT_din[i]};
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd15) begin
                    cnt_d   = '0;
                    state_d = WR_END;
                end
            end
            WR_END: begin
                ok_d    = (DAT_din == 4'hF) && crc_match;
                cnt_d   = '0;
                state_d = WR_TURN;
            end
            WR_TURN: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd1) begin
                    cnt_d   = '0;
                    state_d = WR_STATUS;
                end
            end
            WR_STATUS: begin
                DAT_dout_oe = 1'b1;
                DAT_dout    = {3'b111, status_tok[4]};
                crc_err     = (cnt_q == 16'd0) && !ok_q;
                cnt_d       = cnt_q + 16'd1;
                if (cnt_q == 16'd4) begin
                    cnt_d   = '0;
                    state_d = WR_BUSY;
                end
            end
            WR_BUSY: begin
                DAT_dout_oe = 1'b1;
                DAT_dout    = 4'hE;
                cnt_d       = cnt_q + 16'd1;
                if (cnt_q == BUSY_LAST) begin
                    cnt_d   = '0;
                    state_d = WR_REL;
                end
            end
            WR_REL: begin
                DAT_dout_oe = 1'b1;
                DAT_dout    = 4'hF;
                if (blk_q > 16'd1) begin
                    blk_d   = blk_q - 16'd1;
                    state_d = WR_WAIT;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stop-transmission overrides every transition, including a start in IDLE.
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
            rx_wr_d = 1'b0;
            cnt_d   = '0;
            nib_d   = '0;
        end
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            nib_q     <= '0;
            blk_q     <= '0;
            bsz_q     <= '0;
            word_q    <= '0;
            rx_data_q <= '0;
            rx_wr_q   <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            crc_q     <= '0;
            rxcrc_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nib_q     <= nib_d;
            blk_q     <= blk_d;
            bsz_q     <= bsz_d;
            word_q    <= word_d;
            rx_data_q <= rx_data_d;
            rx_wr_q   <= rx_wr_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            crc_q     <= crc_d;
            rxcrc_q   <= rxcrc_d;
        end
    end
endmodule

// File: tb/tb_sd_card_dat.sv
// Directed bench for sd_card_dat: table-driven single read plus hand sequences for write,
// start collision, abort, mid-busy reset and zero-length transfers.
module tb_sd_card_dat;
    localparam int NAC  = 2;
    localparam int BUSY = 8;
`ifdef SD_CARD_DAT_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        sd_clk = 1'b0;
    logic        rst, rd_start, wr_start, abort, multiple;
    logic [11:0] block_sz;
    logic [15:0] block_cnt;
    logic [31:0] card_tx_data, card_rx_data;
    logic        card_tx_rd, card_rx_wr;
    logic [3:0]  DAT_din, DAT_dout;
    logic        DAT_dout_oe, busy, crc_err, xfer_done;
    int          checks = 0;
    int          errors = 0;

    always #5 sd_clk = ~sd_clk;

    sd_card_dat #(.NAC(NAC), .BUSY_CYCLES(BUSY)) dut (
        .sd_clk(sd_clk), .rst(rst), .rd_start(rd_start), .wr_start(wr_start), .abort(abort),
        .block_sz(block_sz), .block_cnt(block_cnt), .multiple(multiple),
        .card_tx_data(card_tx_data), .card_tx_rd(card_tx_rd),
        .card_rx_data(card_rx_data), .card_rx_wr(card_rx_wr),
        .DAT_din(DAT_din), .DAT_dout(DAT_dout), .DAT_dout_oe(DAT_dout_oe),
        .busy(busy), .crc_err(crc_err), .xfer_done(xfer_done)
    );

    typedef struct {
        logic       oe;
        logic [3:0] dout;
        logic       rd;
        logic       done;
        logic       bsy;
    } rd_vec_t;

    rd_vec_t     rtab[0:28];
    logic [3:0]  nib_buf[0:63];
    logic [31:0] wbuf[0:3];
    logic [15:0] rc[4];

    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check(name, 64'({DAT_dout_oe, DAT_dout, busy, card_tx_rd, card_rx_wr, crc_err, xfer_done, card_rx_data}),
              64'({1'b0, 4'hF, 5'b00000, 32'h0}));
    endtask

    function automatic logic [15:0] crc_line(input int n, input int line);
        logic [15:0] c;
        logic        b;
        c = 16'h0;
        for (int k = 0; k < n; k++) begin
            b = nib_buf[k][line] ^ c[15];
            c = {c[14:0], 1'b0};
            if (b) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Drives one write block from WR_WAIT through WR_REL and checks the card's response.
    task automatic write_block(input int base, input int nw, input logic [3:0] endnib, input int flip,
                               input logic exp_ok, input logic last, input logic stop_busy);
        logic [15:0] c[4];
        logic [3:0]  nib;
        logic [4:0]  tok;
        DAT_din = 4'hF;
        tick();
        check("wr_wait", 64'({busy, DAT_dout_oe}), 64'({1'b1, 1'b0}));
        DAT_din = 4'h0;
        tick();
        for (int k = 0; k < nw * 8; k++) begin
            nib        = wbuf[base + k / 8][31 - 4 * (k % 8) -: 4];
            nib_buf[k] = nib;
            DAT_din    = nib;
            tick();
            check($sformatf("rx_wr%0d", k), 64'(card_rx_wr), 64'((k % 8) == 7));
            if ((k % 8) == 7) check($sformatf("rx_data%0d", k), 64'(card_rx_data), 64'(wbuf[base + k / 8]));
        end
        for (int i = 0; i < 4; i++) c[i] = crc_line(nw * 8, i);
        if (flip >= 0) c[flip] = c[flip] ^ 16'h0400;
        for (int j = 0; j < 16; j++) begin
            DAT_din = {c[3][15 - j], c[2][15 - j], c[1][15 - j], c[0][15 - j]};
            tick();
        end
        DAT_din = endnib;
        tick();
        DAT_din = 4'hF;
        check("turn1", 64'({busy, DAT_dout_oe}), 64'({1'b1, 1'b0}));
        tick();
        check("turn2", 64'({busy, DAT_dout_oe}), 64'({1'b1, 1'b0}));
        tok = exp_ok ? 5'b00101 : 5'b01011;
        for (int s = 0; s < 5; s++) begin
            tick();
            check($sformatf("status%0d", s), 64'({DAT_dout_oe, DAT_dout, crc_err}),
                  64'({1'b1, 3'b111, tok[4 - s], (s == 0) && !exp_ok}));
        end
        for (int b = 0; b < BUSY; b++) begin
            tick();
            check($sformatf("busy%0d", b), 64'({DAT_dout_oe, DAT_dout}), 64'({1'b1, 4'hE}));
            if (stop_busy && b == 2) return;
        end
        tick();
        check("wr_rel", 64'({DAT_dout_oe, DAT_dout, xfer_done}), 64'({1'b1, 4'hF, 1'b0}));
        tick();
        if (last) check("wr_done", 64'({busy, DAT_dout_oe, xfer_done}), 64'({1'b0, 1'b0, 1'b1}));
        else      check("wr_next", 64'({busy, DAT_dout_oe, xfer_done}), 64'({1'b1, 1'b0, 1'b0}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rd_start = 1'b0; wr_start = 1'b0; abort = 1'b0; multiple = 1'b0;
        block_sz = 12'd4; block_cnt = 16'd0; card_tx_data = 32'h12345678; DAT_din = 4'hF;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Single read, one word: expected DAT sequence per cycle after the start edge.
        for (int k = 0; k < 8; k++) nib_buf[k] = card_tx_data[31 - 4 * k -: 4];
        for (int i = 0; i < 4; i++) rc[i] = CRC_ON ? crc_line(8, i) : 16'h0;
        rtab[0] = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b1};
        rtab[1] = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b1};
        rtab[2] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++) rtab[3 + k] = '{1'b1, nib_buf[k], (k == 0), 1'b0, 1'b1};
        for (int j = 0; j < 16; j++)
            rtab[11 + j] = '{1'b1, {rc[3][15 - j], rc[2][15 - j], rc[1][15 - j], rc[0][15 - j]}, 1'b0, 1'b0, 1'b1};
        rtab[27] = '{1'b1, 4'hF, 1'b0, 1'b0, 1'b1};
        rtab[28] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0};

        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int v = 0; v < 29; v++) begin
            check($sformatf("read%0d", v), 64'({DAT_dout_oe, DAT_dout, card_tx_rd, xfer_done, busy}),
                  64'({rtab[v].oe, rtab[v].dout, rtab[v].rd, rtab[v].done, rtab[v].bsy}));
            if (v < 28) tick();
        end
        tick();

        // Two-block write, correct CRC.
        multiple = 1'b1; block_cnt = 16'd2; block_sz = 12'd8;
        wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'h01234567; wbuf[2] = 32'hA5A55A5A; wbuf[3] = 32'h0F1E2D3C;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        write_block(0, 2, 4'hF, -1, 1'b1, 1'b0, 1'b0);
        write_block(2, 2, 4'hF, -1, 1'b1, 1'b1, 1'b0);
        tick();

        // Single block with one CRC bit flipped on DAT2.
        multiple = 1'b0; block_sz = 12'd4; wbuf[0] = 32'hCAFEF00D;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        write_block(0, 1, 4'hF, 2, !CRC_ON, 1'b1, 1'b0);
        tick();

        // Bad end bit is always rejected.
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        write_block(0, 1, 4'hE, -1, 1'b0, 1'b1, 1'b0);
        tick();

        // Simultaneous starts: read wins (start nibble driven on the third cycle).
        rd_start = 1'b1; wr_start = 1'b1;
        tick();
        rd_start = 1'b0; wr_start = 1'b0;
        check("collide_busy", 64'(busy), 64'(1'b1));
        tick();
        tick();
        check("collide_rd", 64'({DAT_dout_oe, DAT_dout}), 64'({1'b1, 4'h0}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("collide_abort", 64'({DAT_dout_oe, DAT_dout, busy, xfer_done}), 64'({1'b0, 4'hF, 1'b0, 1'b0}));
        tick();

        // Abort in RD_DATA.
        block_sz = 12'd8;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("rd_mid", 64'({DAT_dout_oe, DAT_dout}), 64'({1'b1, 4'h2}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("rd_abort", 64'({DAT_dout_oe, busy, xfer_done, DAT_dout}), 64'({1'b0, 1'b0, 1'b0, 4'hF}));
        tick();
        check("rd_abort_nodone", 64'({busy, xfer_done}), 64'({1'b0, 1'b0}));

        // Reset in WR_BUSY.
        block_sz = 12'd4; wbuf[0] = 32'h89ABCDEF;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        write_block(0, 1, 4'hF, -1, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        check_reset("reset_busy");
        rst = 1'b0;
        tick();

        // Zero-length transfers.
        multiple = 1'b1; block_cnt = 16'd0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("zero_cnt", 64'({xfer_done, DAT_dout_oe, busy}), 64'({1'b1, 1'b0, 1'b0}));
        tick();
        check("zero_cnt_after", 64'({xfer_done, DAT_dout_oe, busy}), 64'({1'b0, 1'b0, 1'b0}));
        multiple = 1'b0; block_sz = 12'd0;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        check("zero_sz", 64'({xfer_done, DAT_dout_oe, busy}), 64'({1'b1, 1'b0, 1'b0}));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
